fib_job_arbiter: RTL and testbench
==================================

Name: fib_job_arbiter

Overview:
- Shares one HLS-generated fib core (`main`) between NREQ independent requesters.
- Arbitrates pending jobs round-robin and drives the core's start pulse and init arguments: n from the requester, a=1, b=0.
- Detects core completion, returns the result plus a cycle count to the winning requester, and aborts jobs that exceed a timeout.
- Sits between the requester fabric and the single `main` instance; it is the only driver of the core's inputs.

Parameters:
NREQ, 4, number of requesters (2..16)
NW, 6, width of job argument n
DW, 32, width of core result
CW, 32, width of cycle counter and timeout
TIMEOUT, 1000000, max cycles in WAIT before abort

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester job pending
req_n  in  NREQ*NW  per-requester argument n, slice i = [i*NW +: NW]
req_ready  out  NREQ  one-hot, 1-cycle job-accept pulse
resp_valid  out  NREQ  one-hot, response held for grantee
resp_data  out  DW  result of granted job
resp_cycles  out  CW  cycles from r_enable pulse to completion
resp_err  out  1  1 = job aborted by timeout, resp_data = 0
resp_ready  in  NREQ  per-requester response accept
core_r_enable  out  1  start pulse to core
core_n  out  NW  init_n_t_a
core_a  out  DW  init_a_t_a, constant 1 while ISSUE
core_b  out  DW  init_b_t_a, constant 0
core_controlArr  out  1  tied 0
core_w_enable  in  1  core done (level, may stay high after completion)
core_result  in  DW  core result, valid when core_w_enable rises
busy  out  1  high in any state except IDLE

Behaviour:
Reset:
- Synchronous. On rst: state=IDLE, rr_ptr=0, all outputs 0, w_prev=1.
- w_prev=1 stops a core done level left high from before reset being taken as completion.
- rst mid-job drops the job with no response. The core is not reset by this block.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick grant g = first set bit searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - Latch n=req_n[g]. Pulse req_ready[g] for exactly 1 cycle. Go to ISSUE.
  - No request: stay.
- ISSUE:
  - core_r_enable=1 for exactly 1 cycle, with core_n=latched n, core_a=1, core_b=0.
  - Clear the cycle counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - Completion is a rising edge: core_w_enable=1 and w_prev=0. On completion, latch resp_data=core_result, resp_cycles=counter+1, resp_err=0, and go to RESP.
  - If counter reaches TIMEOUT-1 without completion: resp_data=0, resp_cycles=TIMEOUT, resp_err=1, go to RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP:
  - resp_valid[g]=1 with data held stable until resp_ready[g]=1.
  - On that cycle: rr_ptr=(g+1) mod NREQ, outputs clear next cycle, go to IDLE.
  - resp_ready of other requesters is ignored.

General rules:
- w_prev registers core_w_enable every cycle in all states.
- core_a, core_b and core_n are held at their last values outside ISSUE. Only core_r_enable qualifies them.
- Minimum job turnaround is 3 cycles plus core latency plus response wait. New requests are not accepted until IDLE.
- req_valid dropping after acceptance has no effect. req_n is sampled only in the IDLE grant cycle.
- Counter saturates at all-ones and never wraps.

Test Plan:
- Single job: req_valid[0]=1, n=40. Core model returns F(n+1) after n+3 cycles.
  -> req_ready[0] pulses once; core_r_enable pulses 1 cycle with core_n=40, a=1, b=0.
  -> resp_valid[0] with resp_data=165580141, resp_cycles=43, resp_err=0.
- Round-robin: all 4 requesters valid with n=10,11,12,13.
  -> grants in order 0,1,2,3, then 0 again if it re-requests.
  -> results 89, 144, 233, 377 returned to the matching requester.
- Stale done level: core_w_enable held high across rst and into a new job, dropping 2 cycles after r_enable and rising later.
  -> completion only on the later rise; no early response.
- Timeout with TIMEOUT=50: core never asserts w_enable.
  -> resp_err=1, resp_data=0, resp_cycles=50; arbiter returns to IDLE after resp_ready.
- Backpressure: hold resp_ready[2]=0 for 20 cycles.
  -> resp_valid[2] and data stable throughout; other req_valid not acknowledged; busy=1.
- Reset mid-WAIT: assert rst for 1 cycle.
  -> next cycle all outputs 0, state IDLE, rr_ptr=0, no response for the aborted job.

Source files
------------

// File: rtl/fib_job_arbiter.sv
// Round-robin front end that time-shares one fib core between NREQ requesters,
// issuing jobs, timing them, and returning result or timeout per grantee.
module fib_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int NW      = 6,
  parameter int DW      = 32,
  parameter int CW      = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*NW-1:0]   req_n,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [DW-1:0]        resp_data,
  output logic [CW-1:0]        resp_cycles,
  output logic                 resp_err,
  input  logic [NREQ-1:0]      resp_ready,
  output logic                 core_r_enable,
  output logic [NW-1:0]        core_n,
  output logic [DW-1:0]        core_a,
  output logic [DW-1:0]        core_b,
  output logic                 core_controlArr,
  input  logic                 core_w_enable,
  input  logic [DW-1:0]        core_result,
  output logic                 busy
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST_C    = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DW-1:0]   a_reg, a_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [DW-1:0]   data_reg, data_next;
  logic [CW-1:0]   cycles_reg, cycles_next;
  logic            err_reg, err_next;
  logic            w_prev_reg;
  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic [NW-1:0]   req_n_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_n_arr[gi]  = req_n[gi*NW +: NW];
      assign req_ready[gi]  = (state_reg == IDLE) && pick_found && (pick_idx == GW'(gi));
      assign resp_valid[gi] = (state_reg == RESP) && (grant_reg == GW'(gi));
    end
  endgenerate

  // Scan from the highest offset down so the nearest requester after rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_reg) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = GW'((int'(rr_ptr_reg) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    n_next      = n_reg;
    a_next      = a_reg;
    count_next  = count_reg;
    data_next   = data_reg;
    cycles_next = cycles_reg;
    err_next    = err_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          n_next     = req_n_arr[pick_idx];
          a_next     = DW'(1);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        count_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (count_reg != '1) count_next = count_reg + CW'(1);
        // Only a rising done edge counts; a level left over from an earlier job is ignored.
        if (core_w_enable && !w_prev_reg) begin
          data_next   = core_result;
          cycles_next = (count_reg == '1) ? count_reg : count_reg + CW'(1);
          err_next    = 1'b0;
          state_next  = RESP;
        end else if (count_reg >= LAST_C) begin
          data_next   = '0;
          cycles_next = TIMEOUT_C;
          err_next    = 1'b1;
          state_next  = RESP;
        end
      end
      RESP: begin
        if (resp_ready[grant_reg]) begin
          rr_ptr_next = (grant_reg == GW'(NREQ - 1)) ? '0 : grant_reg + GW'(1);
          data_next   = '0;
          cycles_next = '0;
          err_next    = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      n_reg      <= '0;
      a_reg      <= '0;
      count_reg  <= '0;
      data_reg   <= '0;
      cycles_reg <= '0;
      err_reg    <= 1'b0;
      w_prev_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      n_reg      <= n_next;
      a_reg      <= a_next;
      count_reg  <= count_next;
      data_reg   <= data_next;
      cycles_reg <= cycles_next;
      err_reg    <= err_next;
      w_prev_reg <= core_w_enable;
    end
  end

  assign resp_data       = data_reg;
  assign resp_cycles     = cycles_reg;
  assign resp_err        = err_reg;
  assign core_r_enable   = (state_reg == ISSUE);
  assign core_n          = n_reg;
  assign core_a          = a_reg;
  assign core_b          = '0;
  assign core_controlArr = 1'b0;
  assign busy            = (state_reg != IDLE);
endmodule

// File: tb/tb_fib_job_arbiter.sv
// Randomized and directed bench for fib_job_arbiter with a behavioural fib core
// and a job-level reference model (round-robin pick, Fibonacci result, latency/timeout).
module tb_fib_job_arbiter;
  localparam int NREQ = 4;
  localparam int NW   = 6;
  localparam int DW   = 32;
  localparam int CW   = 32;
  localparam int TO   = 50;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*NW-1:0]   req_n = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [DW-1:0]        resp_data;
  logic [CW-1:0]        resp_cycles;
  logic                 resp_err;
  logic [NREQ-1:0]      resp_ready = '0;
  logic                 core_r_enable;
  logic [NW-1:0]        core_n;
  logic [DW-1:0]        core_a;
  logic [DW-1:0]        core_b;
  logic                 core_controlArr;
  logic                 core_w_enable = 1'b0;
  logic [DW-1:0]        core_result = '0;
  logic                 busy;

  fib_job_arbiter #(.NREQ(NREQ), .NW(NW), .DW(DW), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_cycles(resp_cycles),
    .resp_err(resp_err), .resp_ready(resp_ready), .core_r_enable(core_r_enable),
    .core_n(core_n), .core_a(core_a), .core_b(core_b), .core_controlArr(core_controlArr),
    .core_w_enable(core_w_enable), .core_result(core_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int model_ptr = 0;
  int core_lat_cfg = -1;   // -1: latency n+3, 0: never completes, >0: fixed latency
  int core_drop_cfg = 0;   // cycle after issue at which done is lowered
  int ready_pulses = 0;
  logic [NW-1:0] seen_n = '0;
  logic [DW-1:0] seen_a = '0;
  logic [DW-1:0] seen_b = '0;

  function automatic logic [DW-1:0] fib(input int k);
    logic [DW-1:0] x = 0;
    logic [DW-1:0] y = 1;
    logic [DW-1:0] t;
    for (int i = 0; i < k; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++)
      if (mask[i]) return i;
    return -1;
  endfunction

  task automatic expect_job(input int n, input int lat_cfg,
                            output logic [DW-1:0] d, output int cyc, output logic e);
    int lat;
    lat = (lat_cfg < 0) ? n + 3 : lat_cfg;
    if (lat_cfg == 0 || lat > TO) begin
      d = '0; cyc = TO; e = 1'b1;
    end else begin
      d = fib(n + 1); cyc = lat; e = 1'b0;
    end
  endtask

  // Behavioural core: done rises `lat` cycles after the r_enable pulse.
  initial begin
    int lat;
    int drop;
    forever begin
      @(negedge clk);
      if (core_r_enable === 1'b1) begin
        seen_n = core_n; seen_a = core_a; seen_b = core_b;
        lat  = (core_lat_cfg < 0) ? int'(core_n) + 3 : core_lat_cfg;
        drop = core_drop_cfg;
        @(posedge clk);
        for (int k = 0; k < 200; k++) begin
          if (k > 0) @(posedge clk);
          #1;
          if (rst || busy !== 1'b1 || resp_valid != '0) break;
          if (k == drop) core_w_enable = 1'b0;
          if (core_lat_cfg != 0 && k == lat - 1) begin
            core_result   = fib(int'(seen_n) + 1);
            core_w_enable = 1'b1;
            break;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (req_ready != '0) ready_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output logic [NREQ-1:0] r, output bit ok);
    r = '0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin r = req_ready; ok = 1'b1; return; end
    end
  endtask

  task automatic wait_resp(output int g, output logic [DW-1:0] d, output logic [CW-1:0] c,
                           output logic e, output bit ok);
    g = -1; d = '0; c = '0; e = 1'b0; ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        g = idx_of(resp_valid); d = resp_data; c = resp_cycles; e = resp_err; ok = 1'b1;
        $display("resp: req %0d data %0d cycles %0d err %0b", g, d, c, e);
        return;
      end
    end
  endtask

  task automatic accept(input int g);
    step();
    resp_ready = '0;
    resp_ready[g] = 1'b1;
    step();
    resp_ready = '0;
  endtask

  task automatic test_reset();
    req_valid = '0; resp_ready = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0; model_ptr = 0;
    @(negedge clk);
    total_cnt++;
    if ({req_ready, resp_valid, core_r_enable, busy, resp_err} !== '0)
      $display("FAIL reset_ctrl: got %b, expected 0", {req_ready, resp_valid, core_r_enable, busy, resp_err});
    else pass_cnt++;
    total_cnt++;
    if (resp_data !== '0 || resp_cycles !== '0)
      $display("FAIL reset_data: got data %0d cycles %0d, expected 0 0", resp_data, resp_cycles);
    else pass_cnt++;
    total_cnt++;
    if (core_n !== '0 || core_a !== '0 || core_b !== '0 || core_controlArr !== 1'b0)
      $display("FAIL reset_core: got n %0d a %0d b %0d, expected 0", core_n, core_a, core_b);
    else pass_cnt++;
  endtask

  task automatic test_single_job();
    logic [NREQ-1:0] r; bit ok; int g; logic [DW-1:0] d, ed; logic [CW-1:0] c; logic e, ee; int ec;
    int rp0;
    step();
    core_lat_cfg = -1; core_drop_cfg = 0;
    req_n[0 +: NW] = 6'd40; req_valid = 4'b0001;
    rp0 = ready_pulses;
    wait_ready(r, ok);
    total_cnt++;
    if (!ok || r !== 4'b0001) $display("FAIL single_ready: got %b, expected 0001", r);
    else pass_cnt++;
    step();
    req_valid = '0;
    @(negedge clk);
    total_cnt++;
    if (core_r_enable !== 1'b1 || core_n !== 6'd40 || core_a !== 32'd1 || core_b !== 32'd0)
      $display("FAIL single_issue: got en %b n %0d a %0d b %0d, expected 1 40 1 0",
               core_r_enable, core_n, core_a, core_b);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (core_r_enable !== 1'b0) $display("FAIL single_pulse: got r_enable %b, expected 0", core_r_enable);
    else pass_cnt++;
    wait_resp(g, d, c, e, ok);
    expect_job(40, -1, ed, ec, ee);
    total_cnt++;
    if (!ok || g !== 0 || d !== 32'd165580141 || d !== ed || c !== CW'(ec) || e !== ee)
      $display("FAIL single_resp: got req %0d data %0d cycles %0d err %b, expected 0 %0d %0d %b",
               g, d, c, e, ed, ec, ee);
    else pass_cnt++;
    accept(0);
    model_ptr = 1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || resp_valid !== '0 || resp_data !== '0)
      $display("FAIL single_release: got busy %b valid %b data %0d, expected 0 0 0", busy, resp_valid, resp_data);
    else pass_cnt++;
    total_cnt++;
    if (ready_pulses - rp0 !== 1) $display("FAIL single_ready_count: got %0d, expected 1", ready_pulses - rp0);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] r, mask; bit ok; int g, eg, en; logic [DW-1:0] d, ed; logic [CW-1:0] c;
    logic e, ee; int ec; int nv [NREQ];
    step();
    rst = 1'b1; step(); rst = 1'b0; model_ptr = 0;
    core_lat_cfg = -1;
    mask = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin nv[i] = 10 + i; req_n[i*NW +: NW] = NW'(nv[i]); end
    req_valid = mask;
    for (int j = 0; j < 5; j++) begin
      wait_ready(r, ok);
      eg = rr_pick(mask, model_ptr);
      total_cnt++;
      if (!ok || r !== (NREQ'(1) << eg)) $display("FAIL rr_grant: got %b, expected req %0d", r, eg);
      else pass_cnt++;
      en = nv[eg];
      step();
      if (j == 0) begin nv[0] = 5; req_n[0 +: NW] = 6'd5; end
      else mask[eg] = 1'b0;
      req_valid = mask;
      wait_resp(g, d, c, e, ok);
      expect_job(en, -1, ed, ec, ee);
      total_cnt++;
      if (!ok || g !== eg || d !== ed || c !== CW'(ec) || e !== ee || seen_n !== NW'(en))
        $display("FAIL rr_resp: got req %0d data %0d cycles %0d n %0d, expected %0d %0d %0d %0d",
                 g, d, c, seen_n, eg, ed, ec, en);
      else pass_cnt++;
      accept(eg);
      model_ptr = (eg + 1) % NREQ;
    end
  endtask

  task automatic test_random_jobs();
    logic [NREQ-1:0] r, mask; bit ok; int g, eg, lat_cfg, sel, dly, rp0;
    logic [DW-1:0] d, ed; logic [CW-1:0] c; logic e, ee; int ec; int nv [NREQ];
    for (int it = 0; it < 20; it++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        nv[i] = $urandom_range(0, 40);
        req_n[i*NW +: NW] = NW'(nv[i]);
      end
      sel = $urandom_range(0, 9);
      lat_cfg = (sel < 6) ? -1 : (sel < 8) ? int'($urandom_range(2, 55)) : 0;
      core_lat_cfg = lat_cfg;
      req_valid = mask;
      rp0 = ready_pulses;
      wait_ready(r, ok);
      eg = rr_pick(mask, model_ptr);
      total_cnt++;
      if (!ok || r !== (NREQ'(1) << eg)) $display("FAIL rand_grant: got %b, expected req %0d", r, eg);
      else pass_cnt++;
      step();
      req_valid = '0;
      wait_resp(g, d, c, e, ok);
      expect_job(nv[eg], lat_cfg, ed, ec, ee);
      total_cnt++;
      if (!ok || g !== eg || d !== ed || c !== CW'(ec) || e !== ee)
        $display("FAIL rand_resp: got req %0d data %0d cycles %0d err %b, expected %0d %0d %0d %b",
                 g, d, c, e, eg, ed, ec, ee);
      else pass_cnt++;
      dly = $urandom_range(0, 3);
      for (int k = 0; k < dly; k++) begin
        step();
        resp_ready = NREQ'($urandom) & ~(NREQ'(1) << eg);
        @(negedge clk);
        total_cnt++;
        if (resp_valid !== (NREQ'(1) << eg) || resp_data !== ed)
          $display("FAIL rand_hold: got valid %b data %0d, expected req %0d data %0d", resp_valid, resp_data, eg, ed);
        else pass_cnt++;
      end
      accept(eg);
      model_ptr = (eg + 1) % NREQ;
      total_cnt++;
      if (ready_pulses - rp0 !== 1) $display("FAIL rand_ready_count: got %0d, expected 1", ready_pulses - rp0);
      else pass_cnt++;
    end
  endtask

  task automatic test_stale_done();
    logic [NREQ-1:0] r; bit ok; int g; logic [DW-1:0] d; logic [CW-1:0] c; logic e;
    step();
    core_w_enable = 1'b1;
    rst = 1'b1; step(); step(); rst = 1'b0; model_ptr = 0;
    core_lat_cfg = 12; core_drop_cfg = 2;
    req_n[NW +: NW] = 6'd7; req_valid = 4'b0010;
    wait_ready(r, ok);
    total_cnt++;
    if (!ok || r !== 4'b0010) $display("FAIL stale_grant: got %b, expected 0010", r);
    else pass_cnt++;
    step();
    req_valid = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || resp_valid !== '0)
      $display("FAIL stale_early: got busy %b valid %b, expected 1 0000", busy, resp_valid);
    else pass_cnt++;
    wait_resp(g, d, c, e, ok);
    total_cnt++;
    if (!ok || g !== 1 || d !== fib(8) || c !== CW'(12) || e !== 1'b0)
      $display("FAIL stale_resp: got req %0d data %0d cycles %0d err %b, expected 1 %0d 12 0", g, d, c, e, fib(8));
    else pass_cnt++;
    accept(1);
    model_ptr = 2;
    core_drop_cfg = 0;
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] r; bit ok; int g; logic [DW-1:0] d, ed; logic [CW-1:0] c; logic e, ee; int ec;
    int cfgs [3] = '{0, 51, 50};
    for (int j = 0; j < 3; j++) begin
      core_lat_cfg = cfgs[j];
      req_n[2*NW +: NW] = 6'd3; req_valid = 4'b0100;
      wait_ready(r, ok);
      step();
      req_valid = '0;
      wait_resp(g, d, c, e, ok);
      expect_job(3, cfgs[j], ed, ec, ee);
      total_cnt++;
      if (!ok || g !== 2 || d !== ed || c !== CW'(ec) || e !== ee)
        $display("FAIL timeout_resp(lat %0d): got req %0d data %0d cycles %0d err %b, expected 2 %0d %0d %b",
                 cfgs[j], g, d, c, e, ed, ec, ee);
      else pass_cnt++;
      accept(2);
      model_ptr = 3;
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0 || resp_err !== 1'b0)
        $display("FAIL timeout_idle: got busy %b err %b, expected 0 0", busy, resp_err);
      else pass_cnt++;
      step();
    end
    core_lat_cfg = -1;
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] r, ev; bit ok; int g; logic [DW-1:0] d; logic [CW-1:0] c; logic e;
    core_lat_cfg = -1;
    req_n[2*NW +: NW] = 6'd20; req_valid = 4'b0100;
    wait_ready(r, ok);
    step();
    req_valid = '0;
    wait_resp(g, d, c, e, ok);
    total_cnt++;
    if (!ok || g !== 2 || d !== fib(21) || c !== CW'(23) || e !== 1'b0)
      $display("FAIL bp_resp: got req %0d data %0d cycles %0d err %b, expected 2 %0d 23 0", g, d, c, e, fib(21));
    else pass_cnt++;
    step();
    req_valid = 4'b1011; resp_ready = 4'b1011;
    ev = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total_cnt++;
      if (resp_valid !== ev || resp_data !== fib(21) || resp_cycles !== CW'(23) || busy !== 1'b1 || req_ready !== '0)
        $display("FAIL bp_hold: got valid %b data %0d cycles %0d busy %b ready %b, expected 0100 %0d 23 1 0000",
                 resp_valid, resp_data, resp_cycles, busy, req_ready, fib(21));
      else pass_cnt++;
      step();
    end
    req_valid = '0; resp_ready = '0;
    accept(2);
    model_ptr = 3;
  endtask

  task automatic test_reset_mid_wait();
    logic [NREQ-1:0] r; bit ok; int viol, g, eg; logic [DW-1:0] d; logic [CW-1:0] c; logic e;
    core_lat_cfg = -1;
    req_n[3*NW +: NW] = 6'd30; req_valid = 4'b1000;
    wait_ready(r, ok);
    total_cnt++;
    if (!ok || r !== (NREQ'(1) << rr_pick(4'b1000, model_ptr)))
      $display("FAIL rstw_grant: got %b, expected 1000", r);
    else pass_cnt++;
    step();
    req_valid = '0;
    repeat (5) @(negedge clk);
    step();
    rst = 1'b1; step(); rst = 1'b0; model_ptr = 0;
    @(negedge clk);
    total_cnt++;
    if ({req_ready, resp_valid, core_r_enable, busy, resp_err} !== '0 || resp_data !== '0 ||
        resp_cycles !== '0 || core_n !== '0 || core_a !== '0)
      $display("FAIL rstw_outputs: got ctrl %b data %0d cycles %0d n %0d a %0d, expected all 0",
               {req_ready, resp_valid, core_r_enable, busy, resp_err}, resp_data, resp_cycles, core_n, core_a);
    else pass_cnt++;
    viol = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (resp_valid !== '0 || busy !== 1'b0) viol++;
    end
    total_cnt++;
    if (viol !== 0) $display("FAIL rstw_no_resp: got %0d active cycles, expected 0", viol);
    else pass_cnt++;
    step();
    req_n[0 +: NW] = 6'd9; req_n[3*NW +: NW] = 6'd4; req_valid = 4'b1001;
    eg = rr_pick(4'b1001, model_ptr);
    wait_ready(r, ok);
    total_cnt++;
    if (!ok || r !== (NREQ'(1) << eg)) $display("FAIL rstw_ptr: got %b, expected req %0d", r, eg);
    else pass_cnt++;
    step();
    req_valid = '0;
    wait_resp(g, d, c, e, ok);
    total_cnt++;
    if (!ok || g !== eg || d !== fib(10) || c !== CW'(12) || e !== 1'b0)
      $display("FAIL rstw_next: got req %0d data %0d cycles %0d err %b, expected %0d %0d 12 0", g, d, c, e, eg, fib(10));
    else pass_cnt++;
    accept(eg);
    model_ptr = (eg + 1) % NREQ;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_random_jobs();
    test_stale_done();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
